// File: rtl/cla_adder_pipe.sv
// cla_adder_pipe -- pipelined Brent-Kung carry-lookahead adder/subtractor.
//
// Stages: S0 operand register, optional S1 mid register (MID_REG=1) between
// the G/P up-sweep and the carry down-sweep, S2 result register.
// Latency 2 + MID_REG cycles. Every stage holds its data when it has a valid
// entry and the stage below cannot take it. Bubbles collapse, and throughput is
// one result per cycle.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     input handshake (in_ready is combinational)
//   a, b, sub, tag        operands, subtract select, 4-bit sideband
//   out_valid/out_ready   output handshake
//   sum, cout             result modulo 2^WIDTH, carry out of the MSB
//   z, v, n               zero / signed overflow / negative flags
//   out_tag               tag that travelled with this result
//
// Build option: define CLA_FLAGS_EN to compute z/v/n. When it is undefined,
// z, v and n are tied to 0.

module cla_adder_pipe #(
  parameter int WIDTH   = 32,
  parameter int MID_REG = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic [3:0]       tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             z,
  output logic             v,
  output logic             n,
  output logic [3:0]       out_tag
);
  localparam int LVL = $clog2(WIDTH);

  logic             v0, v1, rdy0, rdy1, rdy2;
  logic [WIDTH-1:0] a0, b0, bx;
  logic             sub0;
  logic [3:0]       tag0;

  // Signals crossing the optional mid register.
  logic [WIDTH-1:0] p0m;
  logic             cim, grm, prm;
  logic [3:0]       tagm;

  assign rdy2     = !out_valid || out_ready;
  assign rdy0     = !v0 || rdy1;
  assign in_ready = rdy0;

  // ---------------- S0: operand register ----------------
  always_ff @(posedge clk) begin
    if (reset) v0 <= 1'b0;
    else if (rdy0) v0 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (!reset && rdy0 && in_valid) begin
      a0   <= a;
      b0   <= b;
      sub0 <= sub;
      tag0 <= tag;
    end
  end

  // Subtraction is A + ~B + 1, so the carry-in is the sub bit itself.
  assign bx = sub0 ? ~b0 : b0;

  // ---------------- up-sweep: group generate/propagate ----------------
  // Level l holds WIDTH>>l groups, and group j spans bits [j*2^l +: 2^l].
  for (genvar l = 0; l <= LVL; l++) begin : up
    logic [(WIDTH>>l)-1:0] g, p;
    if (l == 0) begin : g_leaf
      assign g = a0 & bx;
      assign p = a0 ^ bx;
    end else begin : g_node
      for (genvar j = 0; j < (WIDTH>>l); j++) begin : g_cell
        assign g[j] = up[l-1].g[2*j+1] | (up[l-1].p[2*j+1] & up[l-1].g[2*j]);
        assign p[j] = up[l-1].p[2*j+1] & up[l-1].p[2*j];
      end
    end
  end

  // ---------------- optional S1: mid register ----------------
  if (MID_REG != 0) begin : g_mid
    assign rdy1 = !v1 || rdy2;
    always_ff @(posedge clk) begin
      if (reset) v1 <= 1'b0;
      else if (rdy1) v1 <= v0;
    end
    always_ff @(posedge clk) begin
      if (rdy1 && v0) begin
        p0m  <= up[0].p;
        cim  <= sub0;
        tagm <= tag0;
        grm  <= up[LVL].g[0];
        prm  <= up[LVL].p[0];
      end
    end
  end else begin : g_nomid
    assign rdy1 = rdy2;
    assign v1   = v0;
    assign p0m  = up[0].p;
    assign cim  = sub0;
    assign tagm = tag0;
    assign grm  = up[LVL].g[0];
    assign prm  = up[LVL].p[0];
  end

  // ---------------- down-sweep: carries ----------------
  // dn[l].c[j] is the carry into group j of level l. A low child inherits its
  // parent's carry-in. A high child gets Gl | Pl&cin from its low sibling.
  // Only the low (even) groups' G/P are needed, so only those cross the mid
  // register.
  for (genvar l = 0; l <= LVL; l++) begin : dn
    logic [(WIDTH>>l)-1:0] c;
    if (l == LVL) begin : g_root
      assign c = cim;
    end else begin : g_node
      logic [(WIDTH>>(l+1))-1:0] gl, pl, glm, plm;
      for (genvar k = 0; k < (WIDTH>>(l+1)); k++) begin : g_lo
        assign gl[k] = up[l].g[2*k];
        assign pl[k] = up[l].p[2*k];
      end
      if (MID_REG != 0) begin : g_mr
        always_ff @(posedge clk) begin
          if (rdy1 && v0) begin
            glm <= gl;
            plm <= pl;
          end
        end
      end else begin : g_nmr
        assign glm = gl;
        assign plm = pl;
      end
      for (genvar j = 0; j < (WIDTH>>l); j++) begin : g_c
        if (j % 2 == 0) begin : g_even
          assign c[j] = dn[l+1].c[j/2];
        end else begin : g_odd
          assign c[j] = glm[j/2] | (plm[j/2] & dn[l+1].c[j/2]);
        end
      end
    end
  end

  logic [WIDTH-1:0] sum_c;
  logic             cout_c;
  assign sum_c  = p0m ^ dn[0].c;
  assign cout_c = grm | (prm & cim);

  // ---------------- S2: result register ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      out_tag   <= '0;
    end else begin
      if (rdy2) out_valid <= v1;
      if (rdy2 && v1) begin
        sum     <= sum_c;
        cout    <= cout_c;
        out_tag <= tagm;
      end
    end
  end

`ifdef CLA_FLAGS_EN
  // The flags are registered alongside the sum. This keeps them at 0 through
  // reset rather than decoding z=1 from the cleared sum.
  always_ff @(posedge clk) begin
    if (reset) begin
      z <= 1'b0;
      v <= 1'b0;
      n <= 1'b0;
    end else if (rdy2 && v1) begin
      z <= (sum_c == '0);
      n <= sum_c[WIDTH-1];
      v <= dn[0].c[WIDTH-1] ^ cout_c;
    end
  end
`else
  assign z = 1'b0;
  assign v = 1'b0;
  assign n = 1'b0;
`endif

endmodule
